// File: rtl/wb_commit_buffer.sv
// Writeback commit buffer: DEPTH-entry FIFO between MEM and the commit point.
// Optional WB_DEBUG_TRACE_EN adds debug_wb_* trace outputs.
module wb_commit_buffer #(
  parameter int              DW       = 32,
  parameter int              RW       = 5,
  parameter int              DEPTH    = 2,
  parameter logic [DW-1:0]   RESET_PC = 32'hbfc00000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_pc,
  input  logic [DW-1:0]            in_result,
  input  logic [RW-1:0]            in_wreg,
  input  logic                     in_wen,
  input  logic                     in_hilo_we,
  input  logic [2*DW-1:0]          in_hilo,
  input  logic                     stall,
  input  logic                     flush,
  output logic [DW-1:0]            pc_out,
  output logic [DW-1:0]            result_out,
  output logic [RW-1:0]            wreg_out,
  output logic                     regwrite,
  output logic                     hilo_write,
  output logic [2*DW-1:0]          hilo_out,
  input  logic [RW-1:0]            fwd_reg,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [DW-1:0]            debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [RW-1:0]            debug_wb_rf_wnum,
  output logic [DW-1:0]            debug_wb_rf_wdata
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DW-1:0]   pc;
    logic [DW-1:0]   result;
    logic [RW-1:0]   wreg;
    logic            wen;
    logic            hilo_we;
    logic [2*DW-1:0] hilo;
  } wb_ent_t;

  wb_ent_t       mem [DEPTH];
  wb_ent_t       head;
  wb_ent_t       in_ent;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = (count != '0) & ~stall & ~flush;
  assign head     = mem[rptr];

  always_comb begin
    in_ent         = '0;
    in_ent.pc      = in_pc;
    in_ent.result  = in_result;
    in_ent.wreg    = in_wreg;
    in_ent.wen     = in_wen;
    in_ent.hilo_we = in_hilo_we;
    in_ent.hilo    = in_hilo;
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_ent;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_out     <= RESET_PC;
      result_out <= '0;
      wreg_out   <= '0;
      regwrite   <= 1'b0;
      hilo_write <= 1'b0;
      hilo_out   <= '0;
    end else if (flush) begin
      regwrite   <= 1'b0;
      hilo_write <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        pc_out     <= head.pc;
        result_out <= head.result;
        wreg_out   <= head.wreg;
        regwrite   <= head.wen & (head.wreg != '0);
        hilo_write <= head.hilo_we;
        hilo_out   <= head.hilo;
      end else begin
        regwrite   <= 1'b0;
        hilo_write <= 1'b0;
      end
    end
  end

  // Oldest to youngest so the youngest match wins; commit reg is lowest.
  always_comb begin
    wb_ent_t e;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    e        = '0;
    if (regwrite && (wreg_out == fwd_reg) && (fwd_reg != '0)) begin
      fwd_hit  = 1'b1;
      fwd_data = result_out;
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = mem[rptr + AW'(i)];
      if ((CW'(i) < count) && e.wen &&
          (e.wreg == fwd_reg) && (fwd_reg != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = e.result;
      end
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = pc_out;
  assign debug_wb_rf_wen   = {4{regwrite}};
  assign debug_wb_rf_wnum  = wreg_out;
  assign debug_wb_rf_wdata = result_out;
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Scoreboard bench for wb_commit_buffer: driver queues expected commits,
// a negedge monitor pops and compares on each new committed pc.
module tb_wb_commit_buffer;

  localparam logic [31:0] RPC = 32'hbfc00000;

  logic        clk = 0;
  logic        resetn = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_pc = 0;
  logic [31:0] in_result = 0;
  logic [4:0]  in_wreg = 0;
  logic        in_wen = 0;
  logic        in_hilo_we = 0;
  logic [63:0] in_hilo = 0;
  logic        stall = 0;
  logic        flush = 0;
  logic [31:0] pc_out;
  logic [31:0] result_out;
  logic [4:0]  wreg_out;
  logic        regwrite;
  logic        hilo_write;
  logic [63:0] hilo_out;
  logic [4:0]  fwd_reg = 0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [1:0]  count;

  wb_commit_buffer dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result),
    .in_wreg(in_wreg), .in_wen(in_wen),
    .in_hilo_we(in_hilo_we), .in_hilo(in_hilo),
    .stall(stall), .flush(flush),
    .pc_out(pc_out), .result_out(result_out),
    .wreg_out(wreg_out), .regwrite(regwrite),
    .hilo_write(hilo_write), .hilo_out(hilo_out),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  wreg;
    logic        rw;
    logic        hw;
    logic [63:0] hilo;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 0;
  logic [31:0] prev_pc = RPC;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] res,
                      input logic [4:0] wr, input logic we,
                      input logic hwe, input logic [63:0] hl,
                      input bit track);
    int n = 0;
    exp_t e;
    in_pc = pc; in_result = res; in_wreg = wr;
    in_wen = we; in_hilo_we = hwe; in_hilo = hl;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    if (track) begin
      e.pc = pc; e.res = res; e.wreg = wr;
      e.rw = we && (wr != 0); e.hw = hwe; e.hilo = hl;
      expq.push_back(e);
    end
    step();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && pc_out !== prev_pc) begin
        prev_pc = pc_out;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit act=%h exp=none", pc_out);
        end else begin
          e = expq.pop_front();
          chk("c_pc", 64'(pc_out), 64'(e.pc));
          chk("c_result", 64'(result_out), 64'(e.res));
          chk("c_wreg", 64'(wreg_out), 64'(e.wreg));
          chk("c_regwrite", 64'(regwrite), 64'(e.rw));
          chk("c_hilo_write", 64'(hilo_write), 64'(e.hw));
          chk("c_hilo", hilo_out, e.hilo);
        end
      end
    end
  end

  initial begin
    #3 resetn = 0;
    #1;
    chk("rst_pc", 64'(pc_out), 64'(RPC));
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_hilo_write", 64'(hilo_write), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    prev_pc = RPC;
    mon_en = 1;
    step();

    // back-to-back
    push(32'h100, 32'h11, 5'd3, 1, 0, 64'h0, 1);
    push(32'h104, 32'h22, 5'd4, 1, 0, 64'h0, 1);
    push(32'h108, 32'h33, 5'd5, 1, 1, 64'h1234_5678_9abc_def0, 1);
    idle();
    repeat (3) step();
    chk("idle_regwrite", 64'(regwrite), 64'd0);

    // stall with three offers
    fork
      begin
        stall = 1;
        repeat (4) step();
        chk("stall_count", 64'(count), 64'd2);
        chk("stall_ready", 64'(in_ready), 64'd0);
        stall = 0;
        step();
        chk("release_count", 64'(count), 64'd1);
      end
      begin
        push(32'h500, 32'h50, 5'd10, 1, 0, 64'h0, 1);
        push(32'h504, 32'h54, 5'd11, 1, 0, 64'h0, 1);
        push(32'h508, 32'h58, 5'd12, 1, 0, 64'h0, 1);
        idle();
      end
    join
    repeat (3) step();

    // wreg 0 never writes, never forwards
    fwd_reg = 0;
    push(32'h200, 32'hdead, 5'd0, 1, 0, 64'h0, 1);
    idle();
    @(negedge clk);
    chk("fwd_r0_hit", 64'(fwd_hit), 64'd0);
    repeat (3) step();

    // forwarding youngest-first
    stall = 1;
    step();
    push(32'h300, 32'hA, 5'd7, 1, 0, 64'h0, 1);
    push(32'h304, 32'hB, 5'd7, 1, 0, 64'h0, 1);
    idle();
    fwd_reg = 7;
    @(negedge clk);
    chk("fwd_buf_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_buf_data", 64'(fwd_data), 64'hB);
    fwd_reg = 8;
    #1;
    chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_miss_data", 64'(fwd_data), 64'd0);
    fwd_reg = 7;
    step();
    stall = 0;
    step();
    step();
    @(negedge clk);
    chk("fwd_cr_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_cr_data", 64'(fwd_data), 64'hB);
    step();
    @(negedge clk);
    chk("fwd_gone_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_gone_data", 64'(fwd_data), 64'd0);
    repeat (2) step();

    // flush with full buffer and a simultaneous push
    push(32'h400, 32'h44, 5'd9, 1, 1, 64'hfeed_0000_0000_beef, 1);
    push(32'h404, 32'h45, 5'd9, 1, 0, 64'h0, 0);
    stall = 1;
    push(32'h408, 32'h46, 5'd9, 1, 0, 64'h0, 0);
    idle();
    @(negedge clk);
    chk("pre_flush_count", 64'(count), 64'd2);
    chk("pre_flush_rw", 64'(regwrite), 64'd1);
    chk("pre_flush_hw", 64'(hilo_write), 64'd1);
    step();
    chk("stall_hold_rw", 64'(regwrite), 64'd1);
    in_pc = 32'h40c; in_valid = 1; flush = 1;
    step();
    flush = 0; in_valid = 0; stall = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_rw", 64'(regwrite), 64'd0);
    chk("flush_hw", 64'(hilo_write), 64'd0);
    chk("flush_pc_hold", 64'(pc_out), 64'h400);
    repeat (5) step();
    chk("queue_empty", 64'(expq.size()), 64'd0);

    // reset mid-operation
    stall = 1;
    push(32'h600, 32'h60, 5'd6, 1, 0, 64'h0, 0);
    idle();
    mon_en = 0;
    @(negedge clk);
    resetn = 0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_pc", 64'(pc_out), 64'(RPC));
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    step();
    resetn = 1;
    stall = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
